barrel_shifter_arbiter: RTL
===========================

Name: barrel_shifter_arbiter

Overview:
- Shares one multi_function_barrel_shifter datapath between NUM_REQ requesters.
- Each requester submits a shift job (data, amount, direction) over a valid/ready handshake.
- A round-robin arbiter grants one job per cycle. The rotated result goes into a single-entry output register, tagged with the requester id.
- Sits between the shift clients and the shared shifter instance.

Parameters:
- N, 8, data width in bits (power of 2, ≥2)
- NUM_REQ, 4, number of requesters (power of 2, ≥2)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid_i  in  NUM_REQ  per-requester job valid
- req_ready_o  out  NUM_REQ  per-requester accept; one-hot or zero
- req_data_i  in  NUM_REQ*N  flattened operands; requester k at [k*N +: N]
- req_amount_i  in  NUM_REQ*$clog2(N)  flattened shift amounts
- req_dir_i  in  NUM_REQ  per-requester direction; 0 = rotate left, 1 = rotate right
- res_valid_o  out  1  result register holds a valid result
- res_ready_i  in  1  consumer accepts result
- res_data_o  out  N  rotated data
- res_id_o  out  $clog2(NUM_REQ)  index of the requester that produced res_data_o

Behaviour:
- Reset: asynchronous, active-high. While rst=1 and immediately after:
  - res_valid_o=0, res_data_o=0, res_id_o=0
  - rr_ptr=0, state=EMPTY
  - req_ready_o=0
- Reset mid-operation discards any held result; nothing is replayed.
- FSM with two states:
  - EMPTY: output register has no result.
  - FULL: output register holds a result not yet consumed.
- can_accept = (state==EMPTY) || res_ready_i. This is combinational and allows back-to-back jobs at one job per cycle.
- Arbitration (combinational):
  - Scan req_valid_i starting at index rr_ptr, wrapping modulo NUM_REQ; the first set bit is the grant g.
  - req_ready_o[g]=1 only if can_accept; all other bits are 0.
  - req_ready_o may depend on req_valid_i. Requesters must hold valid and operands stable until ready is seen; they must not wait for ready before asserting valid.
- Accept: the handshake req_valid_i[g] && req_ready_o[g] completes at the clock edge.
  - The granted operands are muxed into the shifter combinationally.
  - The shifter output is captured into res_data_o, and g into res_id_o.
  - res_valid_o=1 and state moves to FULL.
  - rr_ptr = (g+1) mod NUM_REQ.
- Latency: result is visible on the cycle after accept.
- Output handshake: when res_valid_o && res_ready_i with no new accept, state returns to EMPTY and res_valid_o=0. res_data_o and res_id_o keep their last values (don't-care).
- Simultaneous consume and accept in the same cycle: the register loads the new result, state stays FULL, and res_valid_o stays 1.
- Stall: if FULL and res_ready_i=0, then req_ready_o=0 and res_data_o/res_id_o are held stable.
- rr_ptr changes only on accept. With no valid requester, rr_ptr is unchanged and nothing is granted.
- Shift rules:
  - Rotate, not logical shift. Amount 0 passes data unchanged.
  - Amount is the full $clog2(N) field; no saturation is needed.
- Fairness: any continuously valid requester is granted within NUM_REQ accepts.

Decomposition:
- Package barrel_shift_pkg contains:
  - shift_dir_t enum (SHIFT_LEFT=1'b0, SHIFT_RIGHT=1'b1)
  - arb_state_t enum (EMPTY, FULL)
  - function rr_pick(valid, ptr) returning the grant index and a found flag
- Sub-module: one instance of multi_function_barrel_shifter (the existing combinational shifter, parameter N), fed by the grant mux.
- The arbiter, FSM and output register live in the top module.

Test Plan:
- Single job: N=8, requester 2 sends data=8'hF0, amount=1, dir=0 with res_ready_i=1 → req_ready_o=4'b0100 in the same cycle; next cycle res_valid_o=1, res_data_o=8'hE1, res_id_o=2. Repeat with dir=1 → 8'h78. Repeat with amount=0 → 8'hF0.
- Round-robin: all four requesters valid continuously with res_ready_i=1 → grants in order 0,1,2,3,0,…, one result per cycle, res_id_o matching.
- Backpressure: result FULL and res_ready_i=0 for 3 cycles → req_ready_o=0 throughout, res_data_o/res_id_o stable. On release, the consume and next accept happen in the same cycle and res_valid_o stays 1.
- Pointer skip: only requesters 1 and 3 valid with rr_ptr=2 → 3 granted first, then 1; rr_ptr becomes 0 and then 2.
- Reset mid-operation: assert rst asynchronously while FULL with res_ready_i=0 → res_valid_o=0 immediately; after release the next grant goes to requester 0 if it is valid.
- Exhaustive sweep: for every amount 0..7 and both directions on 8'hF0 → result matches a reference rotate model; no X on any output after reset.

Source files
------------

// File: rtl/barrel_shift_pkg.sv
// Shared types and the round-robin pick helper for the barrel shifter arbiter.
// Supports up to MAX_REQ requesters; NUM_REQ must be a power of two.
package barrel_shift_pkg;

  typedef enum logic {
    SHIFT_LEFT  = 1'b0,
    SHIFT_RIGHT = 1'b1
  } shift_dir_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } arb_state_t;

  localparam int MAX_REQ = 64;
  localparam int IDX_W   = 6;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } rr_pick_t;

  // First set bit of valid at or after ptr, wrapping over num_req entries.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input int ptr,
                                       input int num_req);
    rr_pick_t r;
    int       k;
    r = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = (ptr + i) & (num_req - 1);
      if (i < num_req && !r.found && valid[k]) begin
        r.found = 1'b1;
        r.idx   = IDX_W'(k);
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/multi_function_barrel_shifter.sv
// Combinational logarithmic rotator: one stage per amount bit, rotating by 2^s.
module multi_function_barrel_shifter
  import barrel_shift_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0]         data,
  input  logic [$clog2(N)-1:0] amount,
  input  shift_dir_t           dir,
  output logic [N-1:0]         result
);

  localparam int AW = $clog2(N);

  logic [N-1:0]   stage;
  logic [2*N-1:0] dbl;

  // Each stage picks a window out of the doubled word, which is a rotation.
  always_comb begin
    stage = data;
    dbl   = '0;
    for (int s = 0; s < AW; s++) begin
      dbl = {stage, stage};
      if (amount[s]) begin
        if (dir == SHIFT_LEFT) stage = dbl[N - (1 << s) +: N];
        else                   stage = dbl[(1 << s) +: N];
      end
    end
    result = stage;
  end

endmodule

// File: rtl/barrel_shifter_arbiter.sv
// Round-robin arbiter sharing one rotator between NUM_REQ requesters,
// with a single-entry tagged result register.
module barrel_shifter_arbiter
  import barrel_shift_pkg::*;
#(
  parameter int N       = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*N-1:0]           req_data_i,
  input  logic [NUM_REQ*$clog2(N)-1:0]   req_amount_i,
  input  logic [NUM_REQ-1:0]             req_dir_i,
  output logic                           res_valid_o,
  input  logic                           res_ready_i,
  output logic [N-1:0]                   res_data_o,
  output logic [$clog2(NUM_REQ)-1:0]     res_id_o
);

  localparam int AW = $clog2(N);
  localparam int IW = $clog2(NUM_REQ);

  arb_state_t    state, next_state;
  logic [IW-1:0] rr_ptr;
  logic [IW-1:0] grant;
  rr_pick_t      pick;
  logic          can_accept;
  logic          accept;
  logic          unused_idx_bits;
  logic [N-1:0]  sel_data;
  logic [AW-1:0] sel_amount;
  shift_dir_t    sel_dir;
  logic [N-1:0]  shift_result;

  assign pick            = rr_pick(MAX_REQ'(req_valid_i), int'(rr_ptr), NUM_REQ);
  assign grant           = pick.idx[IW-1:0];
  assign unused_idx_bits = ^pick.idx;
  assign can_accept      = (state == EMPTY) || res_ready_i;

  assign sel_data   = req_data_i[grant*N +: N];
  assign sel_amount = req_amount_i[grant*AW +: AW];
  assign sel_dir    = shift_dir_t'(req_dir_i[grant]);

  multi_function_barrel_shifter #(.N(N)) u_shifter (
    .data   (sel_data),
    .amount (sel_amount),
    .dir    (sel_dir),
    .result (shift_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= EMPTY;
    else     state <= next_state;
  end

  // A consume with a simultaneous accept keeps the register FULL.
  always_comb begin
    next_state = state;
    case (state)
      EMPTY:   if (accept) next_state = FULL;
      FULL:    if (!accept && res_ready_i) next_state = EMPTY;
      default: next_state = EMPTY;
    endcase
  end

  always_comb begin
    req_ready_o = '0;
    accept      = 1'b0;
    if (!rst && can_accept && pick.found) begin
      req_ready_o[grant] = 1'b1;
      accept             = 1'b1;
    end
  end

  assign res_valid_o = (state == FULL);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_data_o <= '0;
      res_id_o   <= '0;
      rr_ptr     <= '0;
    end else if (accept) begin
      res_data_o <= shift_result;
      res_id_o   <= grant;
      rr_ptr     <= grant + 1'b1;
    end
  end

endmodule
